// File: rtl/pmod_btn_reader.sv
// Four-button front end for the pmod bicolor LED counter: synchronise, debounce,
// edge pulses, and a 7-bit counter with a manual/auto-increment mode.
module pmod_btn_reader #(
  parameter int DB_CYCLES   = 250000,
  parameter int TICK_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [6:0] count,
  output logic       mode
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int TW  = $clog2(TICK_CYCLES);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_CYCLES - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_e;

  logic [3:0] sync_meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= btn_raw;
      sync_q      <= sync_meta_q;
    end
  end

  // One debouncer per button; a level change needs DB_CYCLES consecutive mismatching samples.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_db
      logic [DBW-1:0] cnt_q, cnt_d;
      logic           lvl_q, lvl_d;
      logic           press_q, press_d;
      logic           rel_q, rel_d;

      always_comb begin
        cnt_d   = '0;
        lvl_d   = lvl_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (sync_q[gi] != lvl_q) begin
          if (cnt_q == DB_LAST) begin
            lvl_d   = sync_q[gi];
            press_d = sync_q[gi];
            rel_d   = ~sync_q[gi];
          end else begin
            cnt_d = cnt_q + DBW'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q   <= '0;
          lvl_q   <= 1'b0;
          press_q <= 1'b0;
          rel_q   <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          lvl_q   <= lvl_d;
          press_q <= press_d;
          rel_q   <= rel_d;
        end
      end

      assign btn_level[gi]   = lvl_q;
      assign btn_press[gi]   = press_q;
      assign btn_release[gi] = rel_q;
    end
  endgenerate

  mode_e          state_q, state_d;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [6:0]     count_q, count_d;
  logic           tick;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = '0;
    tick       = 1'b0;
    unique case (state_q)
      MANUAL: begin
        if (btn_press[3]) state_d = AUTO;
      end
      AUTO: begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        if (btn_press[3]) begin
          state_d    = MANUAL;
          tick_cnt_d = '0;
        end
      end
      default: state_d = MANUAL;
    endcase

    // Clear dominates; otherwise inc, tick and dec combine into one net step mod 128.
    if (btn_press[2]) begin
      count_d = '0;
    end else begin
      count_d = count_q + {6'd0, btn_press[0]} + {6'd0, tick} - {6'd0, btn_press[1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= MANUAL;
      tick_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      count_q    <= count_d;
    end
  end

  assign count = count_q;
  assign mode  = (state_q == AUTO);

endmodule

// File: tb/tb_pmod_btn_reader.sv
// Randomised and directed bench for pmod_btn_reader, checked every cycle against a
// behavioural model built from run-lengths of stable samples and modular counting.
module tb_pmod_btn_reader;

  localparam int DB   = 4;
  localparam int TICK = 10;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [6:0] count;
  logic       mode;

  int vectors;
  int miscompares;

  pmod_btn_reader #(
    .DB_CYCLES  (DB),
    .TICK_CYCLES(TICK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .count      (count),
    .mode       (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: sampled history, per-button mismatch run length, counter, mode, cycles in AUTO.
  logic [3:0] m_s1, m_s2, m_level, m_press, m_release;
  int         m_run [4];
  int         m_count;
  logic       m_mode;
  int         m_k;

  task automatic model_step();
    int         nc;
    int         tk;
    logic [3:0] np, nr;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_release = '0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
      m_count = 0; m_mode = 1'b0; m_k = 0;
    end else begin
      tk = (m_mode && (m_k % TICK == TICK - 1)) ? 1 : 0;
      if (m_press[2]) nc = 0;
      else nc = (m_count + int'(m_press[0]) + tk - int'(m_press[1]) + 128) % 128;
      if (m_press[3]) begin
        m_mode = ~m_mode;
        m_k = 0;
      end else if (m_mode) begin
        m_k++;
      end
      m_count = nc;
      np = '0; nr = '0;
      for (int b = 0; b < 4; b++) begin
        if (m_s2[b] != m_level[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_level[b] = m_s2[b];
            np[b] = m_s2[b];
            nr[b] = ~m_s2[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_press = np; m_release = nr;
      m_s2 = m_s1; m_s1 = btn_raw;
    end
  endtask

  // Advance n clocks: model follows the edge, outputs compared at the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      vectors++;
      if (btn_level !== m_level || btn_press !== m_press || btn_release !== m_release ||
          count !== 7'(m_count) || mode !== m_mode) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t got lvl=%b prs=%b rel=%b cnt=%0d mode=%b want lvl=%b prs=%b rel=%b cnt=%0d mode=%b",
                 $time, btn_level, btn_press, btn_release, count, mode,
                 m_level, m_press, m_release, m_count, m_mode);
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] m);
    btn_raw = m;
    step(8);
    btn_raw = '0;
    step(10);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    btn_raw = '0;
    step(3);
    rst_n = 1'b1;
    step(50);
    check("reset_level", int'(btn_level), 0);
    check("reset_count", int'(count), 0);
    check("reset_mode", int'(mode), 0);

    // Single clean press and release of inc
    btn_raw = 4'b0001;
    step(5);
    check("inc_level_early", int'(btn_level[0]), 0);
    step(1);
    check("inc_level_e6", int'(btn_level[0]), 1);
    check("inc_press_e6", int'(btn_press[0]), 1);
    step(1);
    check("inc_press_e7", int'(btn_press[0]), 0);
    check("inc_count_e7", int'(count), 1);
    step(13);
    btn_raw = 4'b0000;
    step(5);
    check("rel_early", int'(btn_release[0]), 0);
    step(1);
    check("rel_e6", int'(btn_release[0]), 1);
    check("rel_count", int'(count), 1);
    step(10);

    // Bounce shorter than the debounce window, then a long enough hold
    btn_raw = 4'b0001; step(3);
    btn_raw = 4'b0000; step(1);
    btn_raw = 4'b0001; step(3);
    btn_raw = 4'b0000; step(10);
    check("bounce_count", int'(count), 1);
    btn_raw = 4'b0001; step(6);
    btn_raw = 4'b0000; step(10);
    check("hold6_count", int'(count), 2);

    // Wrap and same-cycle combinations
    press(4'b0100); check("clear", int'(count), 0);
    press(4'b0010); check("dec_wrap", int'(count), 127);
    press(4'b0001); check("inc_wrap", int'(count), 0);
    press(4'b0011); check("inc_dec", int'(count), 0);
    for (int i = 0; i < 5; i++) press(4'b0001);
    check("count5", int'(count), 5);
    press(4'b0101); check("inc_clear", int'(count), 0);

    // Auto mode: first tick 10 cycles after entering
    press(4'b1000);
    check("auto_mode", int'(mode), 1);
    check("auto_cnt1", int'(count), 1);
    step(20);
    check("auto_cnt3", int'(count), 3);
    press(4'b1000);
    check("manual_mode", int'(mode), 0);
    check("manual_cnt", int'(count), 3);
    step(30);
    check("frozen_cnt", int'(count), 3);

    // inc coinciding with a tick at 126
    press(4'b0100);
    press(4'b0010);
    press(4'b0010);
    check("cnt126", int'(count), 126);
    btn_raw = 4'b1000; step(10);
    btn_raw = 4'b0001; step(6);
    check("align_before", int'(count), 126);
    step(1);
    check("align_after", int'(count), 0);
    check("align_mode", int'(mode), 1);
    btn_raw = 4'b0000; step(10);
    press(4'b1000);

    // Reset mid-debounce while in AUTO with inc held
    press(4'b1000);
    btn_raw = 4'b0001;
    step(2);
    rst_n = 1'b0;
    step(1);
    check("rst_count", int'(count), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_level", int'(btn_level), 0);
    rst_n = 1'b1;
    step(5);
    check("rst_press_early", int'(btn_press[0]), 0);
    step(1);
    check("rst_press_e6", int'(btn_press[0]), 1);
    check("rst_mode_after", int'(mode), 0);
    step(1);
    check("rst_count_after", int'(count), 1);
    btn_raw = 4'b0000;
    step(10);

    // Random button activity with occasional resets
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) btn_raw[b] = ~btn_raw[b];
      rst_n = ($urandom_range(0, 499) != 0);
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
